// File: rtl/uncache_store_buffer.sv
// Uncached store buffer: queues LSU stores in a DEPTH-entry FIFO and drains them to AXI one write at a time; uncached loads wait behind older stores.
// Latency: a push into an empty buffer with no read in flight raises uncache_wr_req on the next cycle; a load issues one cycle after the buffer drains.
// Backpressure: st_ready drops while all DEPTH entries are occupied (registered count only); ld_req is held off while any store is queued or in flight.
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   st_valid/st_ready, st_addr/size/wstrb/data   LSU store push
//   ld_req/ld_rdy, ld_addr/ld_size       LSU uncached load request
//   ld_ret_valid, ld_ret_data            load return to LSU
//   uncache_wr_*                         AXI-side write request / accept / response
//   uncache_rd_*, uncache_ret_*          AXI-side read request / accept / data
//   sb_empty                             no store queued or in flight
module uncache_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // LSU store push
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [3:0]  st_wstrb,
  input  logic [31:0] st_data,
  // LSU uncached load
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_rdy,
  output logic        ld_ret_valid,
  output logic [31:0] ld_ret_data,
  // AXI-side write channel
  output logic        uncache_wr_req,
  output logic [31:0] uncache_wr_addr,
  output logic [2:0]  uncache_wr_size,
  output logic [3:0]  uncache_wr_wstrb,
  output logic [31:0] uncache_wr_data,
  input  logic        uncache_wr_rdy,
  input  logic        uncache_wr_bvalid,
  // AXI-side read channel
  output logic        uncache_rd_req,
  output logic [31:0] uncache_rd_addr,
  output logic [2:0]  uncache_rd_size,
  input  logic        uncache_rd_rdy,
  input  logic        uncache_ret_valid,
  input  logic [31:0] uncache_ret_data,
  // status
  output logic        sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rstate_t;

  sb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  wstate_t       r_wstate;
  wstate_t       w_wstate_nxt;
  rstate_t       r_rstate;
  rstate_t       w_rstate_nxt;
  logic [31:0]   r_ld_addr;
  logic [2:0]    r_ld_size;

  logic          w_push;
  logic          w_pop;
  logic          w_ld_start;
  logic          w_wr_start;
  sb_entry_t     w_head;

  assign st_ready   = (r_count < FULL_CNT);
  assign w_push     = st_valid && st_ready;
  // The head entry retires only when its write response arrives.
  assign w_pop      = (r_wstate == W_RESP) && uncache_wr_bvalid;
  assign w_ld_start = (r_rstate == R_IDLE) && ld_req && (r_count == '0) && (r_wstate == W_IDLE);
  // A push into an empty buffer starts the write in the same cycle so the
  // request appears one cycle after the push. When a load arrives alongside
  // that push, the load is older and takes the bus first.
  assign w_wr_start = (r_rstate == R_IDLE) && ((r_count != '0) || (w_push && !w_ld_start));
  assign w_head     = r_mem[r_head];

  // write FSM
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_start)        w_wstate_nxt = W_REQ;
      W_REQ:   if (uncache_wr_rdy)    w_wstate_nxt = W_RESP;
      W_RESP:  if (uncache_wr_bvalid) w_wstate_nxt = W_IDLE;
      default:                        w_wstate_nxt = W_IDLE;
    endcase
  end

  // read FSM
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ld_start)        w_rstate_nxt = R_REQ;
      R_REQ:   if (uncache_rd_rdy)    w_rstate_nxt = R_WAIT;
      R_WAIT:  if (uncache_ret_valid) w_rstate_nxt = R_IDLE;
      default:                        w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Entry storage carries no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= {st_addr, st_size, st_wstrb, st_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ld_addr <= '0;
      r_ld_size <= '0;
    end else if (w_ld_start) begin
      r_ld_addr <= ld_addr;
      r_ld_size <= ld_size;
    end
  end

  assign uncache_wr_req   = (r_wstate == W_REQ);
  assign uncache_wr_addr  = w_head.addr;
  assign uncache_wr_size  = w_head.size;
  assign uncache_wr_wstrb = w_head.wstrb;
  assign uncache_wr_data  = w_head.data;

  assign uncache_rd_req   = (r_rstate == R_REQ);
  assign uncache_rd_addr  = r_ld_addr;
  assign uncache_rd_size  = r_ld_size;

  assign ld_rdy           = (r_rstate == R_REQ) && uncache_rd_rdy;
  assign ld_ret_valid     = (r_rstate == R_WAIT) && uncache_ret_valid;
  assign ld_ret_data      = uncache_ret_data;

  assign sb_empty         = (r_count == '0) && (r_wstate == W_IDLE);

endmodule
